// File: rtl/csc_pkg.sv
// Shared definitions for the RGB colour-space-conversion pipeline:
// mode encoding, BT.601-style integer coefficients, chroma offset and
// small helpers for component expansion, mode mapping and saturation.
`timescale 1ns/1ps
package csc_pkg;

  typedef enum logic [1:0] {
    MODE_RGB  = 2'd0,
    MODE_GRAY = 2'd1,
    MODE_YCC  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  // Luma coefficients (sum to 256).
  localparam logic [7:0] C_YR = 8'd77;
  localparam logic [7:0] C_YG = 8'd150;
  localparam logic [7:0] C_YB = 8'd29;
  // Cb coefficients: +128*B - 43*R - 85*G.
  localparam logic [7:0] C_UR = 8'd43;
  localparam logic [7:0] C_UG = 8'd85;
  localparam logic [7:0] C_UB = 8'd128;
  // Cr coefficients: +128*R - 107*G - 21*B.
  localparam logic [7:0] C_VR = 8'd128;
  localparam logic [7:0] C_VG = 8'd107;
  localparam logic [7:0] C_VB = 8'd21;
  // Chroma offset (128 << 8) keeps Cb/Cr sums non-negative.
  localparam logic [16:0] C_OFFSET = 17'd32768;

  // The nine stage-1 products.
  typedef struct packed {
    logic [15:0] yr, yg, yb;
    logic [15:0] ur, ug, ub;
    logic [15:0] vr, vg, vb;
  } csc_prod_t;

  // Left-align a w-bit value in 8 bits and refill the vacated LSBs by
  // repeating the value from its MSB down; w = 8 is a pure passthrough.
  function automatic logic [7:0] expand8(input logic [7:0] v, input int w);
    logic [7:0] e;
    e = '0;
    for (int k = 0; k < 8; k++) e[7-k] = v[w-1-(k%w)];
    return e;
  endfunction

  // The reserved encoding behaves as passthrough.
  function automatic mode_e map_mode(input logic [1:0] m);
    return (m == 2'd3) ? MODE_RGB : mode_e'(m);
  endfunction

  // Take sum>>8 and clamp anything above 255.
  function automatic logic [7:0] sat8(input logic [16:0] s);
    return s[16] ? 8'hFF : s[15:8];
  endfunction

endpackage

// File: rtl/rgb_csc_pipe_if.sv
// Video bus of the colour-space converter: mode request, input timing
// strobes and pixel, output timing strobes and pixel, and applied mode.
`timescale 1ns/1ps
interface rgb_csc_pipe_if #(
  parameter int R_W = 5,
  parameter int G_W = 6,
  parameter int B_W = 5
);
  logic [1:0]     mode_i;
  logic           in_vsync;
  logic           in_hsync;
  logic           in_de;
  logic [R_W-1:0] in_r;
  logic [G_W-1:0] in_g;
  logic [B_W-1:0] in_b;
  logic           out_vsync;
  logic           out_hsync;
  logic           out_de;
  logic [7:0]     out_c0;
  logic [7:0]     out_c1;
  logic [7:0]     out_c2;
  logic [1:0]     mode_active;

  // Video source / sink side.
  modport master (
    output mode_i, in_vsync, in_hsync, in_de, in_r, in_g, in_b,
    input  out_vsync, out_hsync, out_de, out_c0, out_c1, out_c2, mode_active
  );

  // Converter side.
  modport slave (
    input  mode_i, in_vsync, in_hsync, in_de, in_r, in_g, in_b,
    output out_vsync, out_hsync, out_de, out_c0, out_c1, out_c2, mode_active
  );
endinterface

// File: rtl/csc_sync_delay.sv
// Fixed-depth shift register used to delay the timing strobes so they
// stay aligned with the pixel pipeline. Every stage resets to 0.
`timescale 1ns/1ps
module csc_sync_delay #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sr_q [DEPTH];

  // Shift the strobes one stage per clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this small array is reset stage by stage on purpose: stale
      // strobes must never reach the outputs after reset.
      for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the old
      // value of its predecessor, which is what forms the shift chain.
      sr_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/rgb_csc_pipe.sv
// Three-stage RGB -> RGB / grayscale / YCbCr444 converter.
//   stage 1: component expansion to 8 bits, nine products registered
//   stage 2: Y / Cb / Cr 17-bit sums registered
//   stage 3: >>8, saturation, mode mux, blanking, registered outputs
// The mode is sampled on a rising in_vsync and travels down the pipe with
// the pixel, so mode_active changes together with out_vsync.
// Optional build macro: CSC_ROUND_EN adds 128 to each sum before >>8.
`timescale 1ns/1ps
module rgb_csc_pipe
  import csc_pkg::*;
#(
  parameter int         R_W      = 5,
  parameter int         G_W      = 6,
  parameter int         B_W      = 5,
  parameter logic [1:0] MODE_RST = 2'd0
) (
  input logic           clk,
  input logic           rst_n,
  rgb_csc_pipe_if.slave bus
);

`ifdef CSC_ROUND_EN
  localparam logic [16:0] RND = 17'd128;
`else
  localparam logic [16:0] RND = 17'd0;
`endif

  localparam mode_e MODE_RST_E = mode_e'(MODE_RST);

  // ---------------- input side ----------------
  logic [7:0] r8, g8, b8;
  assign r8 = expand8(8'(bus.in_r), R_W);
  assign g8 = expand8(8'(bus.in_g), G_W);
  assign b8 = expand8(8'(bus.in_b), B_W);

  logic  vsync_q;
  mode_e mode_frame_q, mode_frame_d;

  // Mode governing the pixel entering this cycle: a new request is taken
  // only on a vsync rising edge and already applies to that same pixel.
  always_comb begin
    // NOTE: assigning the default first keeps this block free of latches.
    mode_frame_d = mode_frame_q;
    if (bus.in_vsync && !vsync_q) mode_frame_d = map_mode(bus.mode_i);
  end

  // Track vsync level and hold the current frame mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q      <= 1'b0;
      mode_frame_q <= MODE_RST_E;
    end else begin
      vsync_q      <= bus.in_vsync;
      mode_frame_q <= mode_frame_d;
    end
  end

  // ---------------- stage 1 ----------------
  csc_prod_t   prod_d, prod_s1_q;
  logic [23:0] rgb_s1_q;
  mode_e       mode_s1_q;
  logic        de_s1_q;

  // Nine constant products of the expanded components.
  always_comb begin
    prod_d.yr = 16'(r8) * 16'(C_YR);
    prod_d.yg = 16'(g8) * 16'(C_YG);
    prod_d.yb = 16'(b8) * 16'(C_YB);
    prod_d.ur = 16'(r8) * 16'(C_UR);
    prod_d.ug = 16'(g8) * 16'(C_UG);
    prod_d.ub = 16'(b8) * 16'(C_UB);
    prod_d.vr = 16'(r8) * 16'(C_VR);
    prod_d.vg = 16'(g8) * 16'(C_VG);
    prod_d.vb = 16'(b8) * 16'(C_VB);
  end

  // Register products plus the pixel, mode and valid that travel with them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_s1_q <= '0;
      rgb_s1_q  <= '0;
      mode_s1_q <= MODE_RST_E;
      de_s1_q   <= 1'b0;
    end else begin
      prod_s1_q <= prod_d;
      rgb_s1_q  <= {r8, g8, b8};
      mode_s1_q <= mode_frame_d;
      de_s1_q   <= bus.in_de;
    end
  end

  // ---------------- stage 2 ----------------
  logic [16:0] y_d, cb_d, cr_d;
  logic [16:0] y_s2_q, cb_s2_q, cr_s2_q;
  logic [23:0] rgb_s2_q;
  mode_e       mode_s2_q;
  logic        de_s2_q;

  // Sums; chroma adds the offset before subtracting so the 17-bit result
  // never goes negative and never wraps.
  always_comb begin
    y_d  = 17'(prod_s1_q.yr) + 17'(prod_s1_q.yg) + 17'(prod_s1_q.yb) + RND;
    cb_d = 17'(prod_s1_q.ub) + C_OFFSET + RND
         - 17'(prod_s1_q.ur) - 17'(prod_s1_q.ug);
    cr_d = 17'(prod_s1_q.vr) + C_OFFSET + RND
         - 17'(prod_s1_q.vg) - 17'(prod_s1_q.vb);
  end

  // Register the sums alongside the delayed pixel, mode and valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_s2_q    <= '0;
      cb_s2_q   <= '0;
      cr_s2_q   <= '0;
      rgb_s2_q  <= '0;
      mode_s2_q <= MODE_RST_E;
      de_s2_q   <= 1'b0;
    end else begin
      y_s2_q    <= y_d;
      cb_s2_q   <= cb_d;
      cr_s2_q   <= cr_d;
      rgb_s2_q  <= rgb_s1_q;
      mode_s2_q <= mode_s1_q;
      de_s2_q   <= de_s1_q;
    end
  end

  // ---------------- stage 3 ----------------
  logic [7:0] y8, cb8, cr8;
  logic [7:0] c0_d, c1_d, c2_d;
  logic [7:0] c0_q, c1_q, c2_q;
  mode_e      mode_s3_q;

  assign y8  = sat8(y_s2_q);
  assign cb8 = sat8(cb_s2_q);
  assign cr8 = sat8(cr_s2_q);

  // Select the output format and blank the pixel outside active video.
  always_comb begin
    c0_d = rgb_s2_q[23:16];
    c1_d = rgb_s2_q[15:8];
    c2_d = rgb_s2_q[7:0];
    case (mode_s2_q)
      MODE_GRAY: begin c0_d = y8; c1_d = y8;  c2_d = y8;  end
      MODE_YCC:  begin c0_d = y8; c1_d = cb8; c2_d = cr8; end
      default:   ;
    endcase
    if (!de_s2_q) begin
      c0_d = '0;
      c1_d = '0;
      c2_d = '0;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c0_q      <= '0;
      c1_q      <= '0;
      c2_q      <= '0;
      mode_s3_q <= MODE_RST_E;
    end else begin
      c0_q      <= c0_d;
      c1_q      <= c1_d;
      c2_q      <= c2_d;
      mode_s3_q <= mode_s2_q;
    end
  end

  // ---------------- strobes ----------------
  logic [2:0] strobe_s3;

  csc_sync_delay #(
    .WIDTH (3),
    .DEPTH (3)
  ) u_sync_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   ({bus.in_vsync, bus.in_hsync, bus.in_de}),
    .q_o   (strobe_s3)
  );

  assign bus.out_vsync   = strobe_s3[2];
  assign bus.out_hsync   = strobe_s3[1];
  assign bus.out_de      = strobe_s3[0];
  assign bus.out_c0      = c0_q;
  assign bus.out_c1      = c1_q;
  assign bus.out_c2      = c2_q;
  assign bus.mode_active = mode_s3_q;

endmodule

// File: tb/tb_rgb_csc_pipe.sv
// Directed bench for rgb_csc_pipe (565 input, MODE_RST = 0).
// Expected values are hand-computed for both CSC_ROUND_EN settings.
`timescale 1ns/1ps
module tb_rgb_csc_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  rgb_csc_pipe_if #(.R_W(5), .G_W(6), .B_W(5)) bus ();

  rgb_csc_pipe #(
    .R_W(5), .G_W(6), .B_W(5), .MODE_RST(2'd0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef CSC_ROUND_EN
  localparam logic [7:0] Y_RED = 8'd77, Y_GRN = 8'd149, Y_BLU = 8'd29;
`else
  localparam logic [7:0] Y_RED = 8'd76, Y_GRN = 8'd149, Y_BLU = 8'd28;
`endif

  // Advance one clock; sample and drive 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vs, input logic hs, input logic de,
                       input logic [4:0] r, input logic [5:0] g, input logic [4:0] b);
    bus.in_vsync = vs; bus.in_hsync = hs; bus.in_de = de;
    bus.in_r = r; bus.in_g = g; bus.in_b = b;
  endtask

  // One vsync pulse carrying a mode request, no active pixels.
  task automatic start_frame(input logic [1:0] m);
    bus.mode_i = m;
    drive(1'b1, 1'b0, 1'b0, 5'd0, 6'd0, 5'd0);
    step();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 6'd0, 5'd0);
    step();
  endtask

  // Single active pixel followed by blanking with nonzero pixel data;
  // checks the result 3 cycles later and the blanked cycle after it.
  task automatic pixel(input string name, input logic [4:0] r, input logic [5:0] g,
                       input logic [4:0] b, input logic [7:0] e0, input logic [7:0] e1,
                       input logic [7:0] e2, input logic [1:0] emode);
    drive(1'b0, 1'b0, 1'b1, r, g, b);
    step();
    drive(1'b0, 1'b0, 1'b0, r, g, b);
    step();
    step();
    n_vec++;
    if ({bus.out_de, bus.out_c0, bus.out_c1, bus.out_c2, bus.mode_active} !==
        {1'b1, e0, e1, e2, emode}) begin
      n_err++;
      $display("FAIL %s: got de=%b c=(%0d,%0d,%0d) mode=%0d want de=1 c=(%0d,%0d,%0d) mode=%0d",
               name, bus.out_de, bus.out_c0, bus.out_c1, bus.out_c2, bus.mode_active,
               e0, e1, e2, emode);
    end
    step();
    n_vec++;
    if ({bus.out_de, bus.out_c0, bus.out_c1, bus.out_c2} !== 25'd0) begin
      n_err++;
      $display("FAIL %s_blank: got de=%b c=(%0d,%0d,%0d) want all 0",
               name, bus.out_de, bus.out_c0, bus.out_c1, bus.out_c2);
    end
    drive(1'b0, 1'b0, 1'b0, 5'd0, 6'd0, 5'd0);
  endtask

  task automatic test_reset();
    bus.mode_i = 2'd2;
    drive(1'b1, 1'b1, 1'b1, 5'd31, 6'd63, 5'd31);
    step();
    step();
    n_vec++;
    if ({bus.out_vsync, bus.out_hsync, bus.out_de, bus.out_c0, bus.out_c1, bus.out_c2,
         bus.mode_active} !== 29'd0) begin
      n_err++;
      $display("FAIL reset_state: got v=%b h=%b de=%b c=(%0d,%0d,%0d) mode=%0d want all 0",
               bus.out_vsync, bus.out_hsync, bus.out_de, bus.out_c0, bus.out_c1,
               bus.out_c2, bus.mode_active);
    end
    drive(1'b0, 1'b0, 1'b0, 5'd0, 6'd0, 5'd0);
    bus.mode_i = 2'd0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_ycc();
    start_frame(2'd2);
    pixel("ycc_white", 5'd31, 6'd63, 5'd31, 8'd255, 8'd128, 8'd128, 2'd2);
    pixel("ycc_red",   5'd31, 6'd0,  5'd0,  Y_RED,  8'd85,  8'd255, 2'd2);
    pixel("ycc_green", 5'd0,  6'd63, 5'd0,  Y_GRN,  8'd43,  8'd21,  2'd2);
    pixel("ycc_blue",  5'd0,  6'd0,  5'd31, Y_BLU,  8'd255, 8'd107, 2'd2);
  endtask

  task automatic test_gray();
    start_frame(2'd1);
    pixel("gray_red",   5'd31, 6'd0,  5'd0, Y_RED, Y_RED, Y_RED, 2'd1);
    pixel("gray_white", 5'd31, 6'd63, 5'd31, 8'd255, 8'd255, 8'd255, 2'd1);
  endtask

  task automatic test_rgb();
    start_frame(2'd3);   // reserved -> passthrough
    pixel("rsvd_red", 5'd31, 6'd0, 5'd0, 8'd255, 8'd0, 8'd0, 2'd0);
    start_frame(2'd0);
    pixel("rgb_expand", 5'd16, 6'd32, 5'd1, 8'd132, 8'd130, 8'd8, 2'd0);
    pixel("rgb_mixed",  5'd21, 6'd9,  5'd4, 8'd173, 8'd36, 8'd33, 2'd0);
  endtask

  task automatic test_mode_switch();
    // Mid-frame request without vsync must be ignored.
    bus.mode_i = 2'd2;
    step();
    pixel("switch_ignored", 5'd31, 6'd0, 5'd0, 8'd255, 8'd0, 8'd0, 2'd0);
    bus.mode_i = 2'd0;
    step();
    // Vsync rise and mode change in the same cycle, pixel in that cycle.
    bus.mode_i = 2'd2;
    drive(1'b1, 1'b0, 1'b1, 5'd31, 6'd0, 5'd0);
    for (int k = 1; k <= 4; k++) begin
      step();
      drive(1'b0, 1'b0, 1'b0, 5'd0, 6'd0, 5'd0);
      n_vec++;
      if (k < 3) begin
        if ({bus.out_vsync, bus.mode_active} !== 3'b0_00) begin
          n_err++;
          $display("FAIL switch_pre%0d: got vsync=%b mode=%0d want vsync=0 mode=0",
                   k, bus.out_vsync, bus.mode_active);
        end
      end else if (k == 3) begin
        if ({bus.out_vsync, bus.mode_active, bus.out_de, bus.out_c0, bus.out_c1, bus.out_c2}
            !== {1'b1, 2'd2, 1'b1, Y_RED, 8'd85, 8'd255}) begin
          n_err++;
          $display("FAIL switch_edge: got vsync=%b mode=%0d de=%b c=(%0d,%0d,%0d) want 1,2,1,(%0d,85,255)",
                   bus.out_vsync, bus.mode_active, bus.out_de, bus.out_c0, bus.out_c1,
                   bus.out_c2, Y_RED);
        end
      end else begin
        if ({bus.out_vsync, bus.mode_active} !== 3'b0_10) begin
          n_err++;
          $display("FAIL switch_post: got vsync=%b mode=%0d want vsync=0 mode=2",
                   bus.out_vsync, bus.mode_active);
        end
      end
    end
  endtask

  task automatic test_blank();
    // Nonzero pixel with de low, hsync pulse: strobe delay must be 3.
    drive(1'b0, 1'b1, 1'b0, 5'd31, 6'd63, 5'd31);
    for (int k = 1; k <= 4; k++) begin
      step();
      drive(1'b0, 1'b0, 1'b0, 5'd31, 6'd63, 5'd31);
      n_vec++;
      if ({bus.out_hsync, bus.out_de, bus.out_c0, bus.out_c1, bus.out_c2} !==
          {(k == 3), 1'b0, 24'd0}) begin
        n_err++;
        $display("FAIL blank_hsync%0d: got hsync=%b de=%b c=(%0d,%0d,%0d) want hsync=%0d de=0 c=0",
                 k, bus.out_hsync, bus.out_de, bus.out_c0, bus.out_c1, bus.out_c2, (k == 3));
      end
    end
    drive(1'b0, 1'b0, 1'b0, 5'd0, 6'd0, 5'd0);
  endtask

  task automatic test_reset_mid();
    // Currently in mode 2; fill the pipe with active red pixels.
    drive(1'b0, 1'b1, 1'b1, 5'd31, 6'd0, 5'd0);
    for (int k = 0; k < 4; k++) step();
    n_vec++;
    if ({bus.out_de, bus.mode_active} !== 3'b1_10) begin
      n_err++;
      $display("FAIL rstmid_pre: got de=%b mode=%0d want de=1 mode=2",
               bus.out_de, bus.mode_active);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.out_vsync, bus.out_hsync, bus.out_de, bus.out_c0, bus.out_c1, bus.out_c2,
         bus.mode_active} !== 29'd0) begin
      n_err++;
      $display("FAIL rstmid_async: got v=%b h=%b de=%b c=(%0d,%0d,%0d) mode=%0d want all 0",
               bus.out_vsync, bus.out_hsync, bus.out_de, bus.out_c0, bus.out_c1,
               bus.out_c2, bus.mode_active);
    end
    step();
    step();
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 5'd31, 6'd0, 5'd0);
    for (int k = 1; k <= 3; k++) begin
      step();
      drive(1'b0, 1'b0, 1'b0, 5'd0, 6'd0, 5'd0);
      n_vec++;
      if (k < 3) begin
        if ({bus.out_de, bus.out_c0, bus.out_c1, bus.out_c2} !== 25'd0) begin
          n_err++;
          $display("FAIL rstmid_quiet%0d: got de=%b c=(%0d,%0d,%0d) want all 0",
                   k, bus.out_de, bus.out_c0, bus.out_c1, bus.out_c2);
        end
      end else begin
        if ({bus.out_de, bus.out_c0, bus.out_c1, bus.out_c2, bus.mode_active} !==
            {1'b1, 8'd255, 8'd0, 8'd0, 2'd0}) begin
          n_err++;
          $display("FAIL rstmid_first: got de=%b c=(%0d,%0d,%0d) mode=%0d want 1,(255,0,0),0",
                   bus.out_de, bus.out_c0, bus.out_c1, bus.out_c2, bus.mode_active);
        end
      end
    end
  endtask

  initial begin
    bus.mode_i = 2'd0;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 6'd0, 5'd0);
    #1;
    test_reset();
    test_ycc();
    test_gray();
    test_rgb();
    test_mode_switch();
    test_blank();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rgb_csc_pipe.md
RGB_CSC_PIPE -- requirements
Module: rgb_csc_pipe

Interface
REQ-001 Parameter R_W, default 5: input red component width, legal range 4..8.
REQ-002 Parameter G_W, default 6: input green component width, legal range 4..8.
REQ-003 Parameter B_W, default 5: input blue component width, legal range 4..8.
REQ-004 Parameter MODE_RST, default 2'd0: mode_active value after reset.
REQ-005 clk  input  1  clock; rst_n  input  1  reset, asynchronous, active-low.
REQ-006 mode_i  input  2  requested mode: 0 RGB888 passthrough, 1 grayscale (Y on all channels), 2 YCbCr444, 3 reserved (treated as 0).
REQ-007 in_vsync, in_hsync, in_de  input  1 each  input timing strobes.
REQ-008 in_r, in_g, in_b  input  R_W, G_W, B_W  input pixel components.
REQ-009 out_vsync, out_hsync, out_de  output  1 each  timing strobes delayed to match pixel data.
REQ-010 out_c0, out_c1, out_c2  output  8 each  R/G/B (mode 0), Y/Y/Y (mode 1), Y/Cb/Cr (mode 2).
REQ-011 mode_active  output  2  mode applied to the current frame.

Function
REQ-012 Each component SHALL be expanded to 8 bits by MSB replication (value left-aligned, upper bits repeated into vacated LSBs); width 8 SHALL pass unchanged.
REQ-013 Latency SHALL be exactly 3 clk cycles from input to output for data and all three strobes, identical in every mode.
REQ-014 Stage 1: products R*77, G*150, B*29, R*43, G*85, B*128, R*128, G*107, B*21 registered.
REQ-015 Stage 2: Y=77R+150G+29B; Cb=128B-43R-85G+32768; Cr=128R-107G-21B+32768; 17-bit internal sums, no wrap-around.
REQ-016 Stage 3: result = sum>>8, saturated to 0..255; mode multiplexing applied; registered to outputs.
REQ-017 Mode 0 output SHALL equal expanded RGB delayed 3 cycles.
REQ-018 mode_active SHALL update to mode_i (3 mapped to 0) only on a registered rising edge of in_vsync; mode_i changes at any other time SHALL have no effect.
REQ-019 The mode latched at a vsync rising edge SHALL govern the pixel entering in that same cycle and all later pixels; its effect SHALL appear at the outputs 3 cycles later, aligned with out_vsync rising.
REQ-020 out_c0..out_c2 SHALL be 0 in any cycle where out_de is 0.
REQ-021 Simultaneous vsync rising edge and mode_i change SHALL latch the new mode_i value.

Reset
REQ-022 While rst_n is low, all pipeline registers, out_* strobes and out_c* SHALL be 0 and mode_active SHALL equal MODE_RST.
REQ-023 Reset asserted mid-frame SHALL discard in-flight pixels; after release, outputs SHALL stay 0 for 3 cycles, until first valid input propagates.

Configuration
REQ-024 Macro CSC_ROUND_EN: when defined, 128 SHALL be added to Y, Cb, Cr sums before the >>8 (round-half-up), with saturation at 255; when undefined, plain truncation, no rounding term.

Structure
REQ-025 Package csc_pkg SHALL hold the mode encoding constants (MODE_RGB, MODE_GRAY, MODE_YCC), the nine coefficients and the 32768 offset.
REQ-026 Sub-module csc_sync_delay (parametrised width and depth shift register, async reset to 0) SHALL delay vsync/hsync/de by 3.

Verification
REQ-027 Mode 2, white input 565 (31,63,31) -> 3 cycles later out_c = (255,128,128), both macro settings.
REQ-028 Mode 2, red (31,0,0): macro off -> (76,85,255); CSC_ROUND_EN -> (77,85,255), Cr saturated from 256.
REQ-029 Mode 1, red -> out_c0=out_c1=out_c2=76 (off) / 77 (on); mode 0, red -> (255,0,0).
REQ-030 mode_i 0->2 mid-frame: outputs stay RGB until next vsync rising; mode_active and YCbCr switch exactly with out_vsync rising.
REQ-031 in_de low with nonzero pixels -> out_c all 0; strobe delay checked as exactly 3 cycles.
REQ-032 rst_n pulsed low mid-line -> all outputs 0 immediately, mode_active=MODE_RST, first valid output 3 cycles after first post-reset input.
